// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-add multiplier that returns the low DATA_W bits of the product.
// Optional feature MUL_EARLY_EXIT_EN: RUN ends as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy
);
    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   w_sum;
    logic                w_final;
    logic                w_exit;

    // Carry out of the accumulator is discarded: only the low product half is kept.
    assign w_sum   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_final = (r_cnt == CNT_LAST);

`ifdef MUL_EARLY_EXIT_EN
    assign w_exit = (r_mplier == '0);
`else
    assign w_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = start;
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (w_exit || w_final) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= operand_a;
                        r_mplier <= operand_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    // An early exit skips the iteration and publishes the accumulator as-is.
                    if (w_exit) begin
                        r_result <= r_acc;
                    end else begin
                        r_acc    <= w_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (w_final) begin
                            r_result <= w_sum;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule
